// File: rtl/exec_pkg.sv
// Shared types and encodings for the execute stage: ALU operation classes,
// ALU controls, funct3/opcode constants and the multiplier FSM states.
package exec_pkg;

    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_BR    = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_ctrl_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_MUL,
        MS_DONE
    } mul_state_e;

endpackage

// File: rtl/exec_alu.sv
// Combinational integer ALU; also reports the equal / signed-less /
// unsigned-less flags used to resolve branches.
module exec_alu
    import exec_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  alu_ctrl_e         ctrl,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [XLEN-1:0]   result,
    output logic              eq,
    output logic              lt,
    output logic              ltu
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt = op_b[SHW-1:0];
    assign eq    = (op_a == op_b);
    assign lt    = ($signed(op_a) < $signed(op_b));
    assign ltu   = (op_a < op_b);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage_pipe.sv
// Execute stage with valid/ready handshake on both sides, flush, branch
// resolution and an optional XLEN-cycle shift-add multiplier.
module execute_stage_pipe
    import exec_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instruction,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_immediate,
    input  logic [XLEN-1:0]   i_rs1_value,
    input  logic [XLEN-1:0]   i_rs2_value,
    input  logic [1:0]        i_alu_op,
    input  logic              i_alu_src,
    input  logic              i_branch,
    input  logic              i_mem_write,
    input  logic              i_mem_read,
    input  logic              i_mem_to_reg,
    input  logic              i_reg_write,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [31:0]       o_instruction,
    output logic [XLEN-1:0]   o_pc,
    output logic [XLEN-1:0]   o_rs2_value,
    output logic [XLEN-1:0]   o_alu_result,
    output logic              o_branch_taken,
    output logic [XLEN-1:0]   o_jmp_addr,
    output logic              o_mem_write,
    output logic              o_mem_read,
    output logic              o_mem_to_reg,
    output logic              o_reg_write
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] COUNT_INIT = CW'(XLEN - 1);

    mul_state_e       state, next_state;
    alu_ctrl_e        alu_ctrl;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  op_b, alu_result, jmp_addr;
    logic             flag_eq, flag_lt, flag_ltu, branch_cond, taken;
    logic             is_mul, accept, slot_free, direct_load, done_load;

    logic [CW-1:0]    mul_count;
    logic [XLEN-1:0]  mcand, mplier, acc;
    logic [31:0]      pend_instruction;
    logic [XLEN-1:0]  pend_pc, pend_rs2, pend_jmp;
    logic [3:0]       pend_ctrl;
    logic             pend_taken;

    assign funct3      = i_instruction[14:12];
    assign op_b        = i_alu_src ? i_immediate : i_rs2_value;
    assign jmp_addr    = i_pc + i_immediate;
    assign is_mul      = MUL_EN && (i_alu_op == ALU_OP_FUNCT) &&
                         (i_instruction[6:0] == OPCODE_OP) &&
                         (i_instruction[31:25] == FUNCT7_MULDIV);
    assign slot_free   = !o_valid || i_ready;
    assign o_ready     = (state == MS_IDLE) && slot_free;
    assign accept      = i_valid && o_ready && !i_flush;
    assign direct_load = accept && !is_mul;
    assign done_load   = (state == MS_DONE) && slot_free && !i_flush;
    assign taken       = i_branch && branch_cond;

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (i_alu_op)
            ALU_OP_ADD: alu_ctrl = ALU_ADD;
            ALU_OP_BR:  alu_ctrl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // Immediate forms reuse bit 30 as immediate data, so only R-type subtracts
                    F3_ADD:  alu_ctrl = (!i_alu_src && i_instruction[30]) ? ALU_SUB : ALU_ADD;
                    F3_SLL:  alu_ctrl = ALU_SLL;
                    F3_SLT:  alu_ctrl = ALU_SLT;
                    F3_SLTU: alu_ctrl = ALU_SLTU;
                    F3_XOR:  alu_ctrl = ALU_XOR;
                    F3_SR:   alu_ctrl = i_instruction[30] ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_ctrl = ALU_OR;
                    F3_AND:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        branch_cond = 1'b0;
        case (funct3)
            F3_BEQ:  branch_cond = flag_eq;
            F3_BNE:  branch_cond = !flag_eq;
            F3_BLT:  branch_cond = flag_lt;
            F3_BGE:  branch_cond = !flag_lt;
            F3_BLTU: branch_cond = flag_ltu;
            F3_BGEU: branch_cond = !flag_ltu;
            default: branch_cond = 1'b0;
        endcase
    end

    exec_alu #(.XLEN(XLEN)) u_alu (
        .ctrl   (alu_ctrl),
        .op_a   (i_rs1_value),
        .op_b   (op_b),
        .result (alu_result),
        .eq     (flag_eq),
        .lt     (flag_lt),
        .ltu    (flag_ltu)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= MS_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (i_flush) begin
            next_state = MS_IDLE;
        end else begin
            case (state)
                MS_IDLE: if (accept && is_mul) next_state = MS_MUL;
                MS_MUL:  if (mul_count == '0) next_state = MS_DONE;
                MS_DONE: if (slot_free) next_state = MS_IDLE;
                default: next_state = MS_IDLE;
            endcase
        end
    end

    // Multiplier operands and the sideband of the instruction being multiplied
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mul_count        <= '0;
            mcand            <= '0;
            mplier           <= '0;
            acc              <= '0;
            pend_instruction <= '0;
            pend_pc          <= '0;
            pend_rs2         <= '0;
            pend_jmp         <= '0;
            pend_ctrl        <= '0;
            pend_taken       <= 1'b0;
        end else if (accept && is_mul) begin
            mul_count        <= COUNT_INIT;
            mcand            <= i_rs1_value;
            mplier           <= op_b;
            acc              <= '0;
            pend_instruction <= i_instruction;
            pend_pc          <= i_pc;
            pend_rs2         <= i_rs2_value;
            pend_jmp         <= jmp_addr;
            pend_ctrl        <= {i_mem_write, i_mem_read, i_mem_to_reg, i_reg_write};
            pend_taken       <= taken;
        end else if (state == MS_MUL) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand     <= mcand << 1;
            mplier    <= mplier >> 1;
            mul_count <= mul_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid        <= 1'b0;
            o_instruction  <= '0;
            o_pc           <= '0;
            o_rs2_value    <= '0;
            o_alu_result   <= '0;
            o_branch_taken <= 1'b0;
            o_jmp_addr     <= '0;
            o_mem_write    <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_reg_write    <= 1'b0;
        end else if (direct_load) begin
            o_valid        <= 1'b1;
            o_instruction  <= i_instruction;
            o_pc           <= i_pc;
            o_rs2_value    <= i_rs2_value;
            o_alu_result   <= alu_result;
            o_branch_taken <= taken;
            o_jmp_addr     <= jmp_addr;
            o_mem_write    <= i_mem_write;
            o_mem_read     <= i_mem_read;
            o_mem_to_reg   <= i_mem_to_reg;
            o_reg_write    <= i_reg_write;
        end else if (done_load) begin
            o_valid        <= 1'b1;
            o_instruction  <= pend_instruction;
            o_pc           <= pend_pc;
            o_rs2_value    <= pend_rs2;
            o_alu_result   <= acc;
            o_branch_taken <= pend_taken;
            o_jmp_addr     <= pend_jmp;
            {o_mem_write, o_mem_read, o_mem_to_reg, o_reg_write} <= pend_ctrl;
        end else if (i_flush || i_ready) begin
            // Control bits drop together with o_valid so nothing downstream acts on a stale slot
            o_valid        <= 1'b0;
            o_branch_taken <= 1'b0;
            o_mem_write    <= 1'b0;
            o_mem_read     <= 1'b0;
            o_mem_to_reg   <= 1'b0;
            o_reg_write    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_execute_stage_pipe.sv
// Self-checking bench for execute_stage_pipe: directed scenarios plus a
// randomized handshake run compared against an arithmetic reference model.
module tb_execute_stage_pipe;

    localparam int XLEN = 64;

    typedef struct {
        logic [63:0] res;
        logic        taken;
        logic [63:0] jmp;
        logic [63:0] pc;
        logic [63:0] rs2;
        logic [31:0] instr;
        logic        mem_write;
        logic        reg_write;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0, i_ready = 1'b1, i_flush = 1'b0;
    logic [31:0] i_instruction = '0;
    logic [63:0] i_pc = '0, i_immediate = '0, i_rs1_value = '0, i_rs2_value = '0;
    logic [1:0]  i_alu_op = '0;
    logic        i_alu_src = 1'b0, i_branch = 1'b0;
    logic        i_mem_write = 1'b0, i_mem_read = 1'b0, i_mem_to_reg = 1'b0, i_reg_write = 1'b0;

    logic        o_ready, o_valid, o_branch_taken;
    logic [31:0] o_instruction;
    logic [63:0] o_pc, o_rs2_value, o_alu_result, o_jmp_addr;
    logic        o_mem_write, o_mem_read, o_mem_to_reg, o_reg_write;

    logic        n_ready, n_valid, n_branch_taken;
    logic [31:0] n_instruction;
    logic [63:0] n_pc, n_rs2_value, n_alu_result, n_jmp_addr;
    logic        n_mem_write, n_mem_read, n_mem_to_reg, n_reg_write;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    execute_stage_pipe #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_immediate(i_immediate),
        .i_rs1_value(i_rs1_value), .i_rs2_value(i_rs2_value), .i_alu_op(i_alu_op),
        .i_alu_src(i_alu_src), .i_branch(i_branch), .i_mem_write(i_mem_write),
        .i_mem_read(i_mem_read), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_rs2_value(o_rs2_value),
        .o_alu_result(o_alu_result), .o_branch_taken(o_branch_taken), .o_jmp_addr(o_jmp_addr),
        .o_mem_write(o_mem_write), .o_mem_read(o_mem_read), .o_mem_to_reg(o_mem_to_reg),
        .o_reg_write(o_reg_write)
    );

    execute_stage_pipe #(.XLEN(XLEN), .MUL_EN(1'b0)) dut_nomul (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(n_ready),
        .i_instruction(i_instruction), .i_pc(i_pc), .i_immediate(i_immediate),
        .i_rs1_value(i_rs1_value), .i_rs2_value(i_rs2_value), .i_alu_op(i_alu_op),
        .i_alu_src(i_alu_src), .i_branch(i_branch), .i_mem_write(i_mem_write),
        .i_mem_read(i_mem_read), .i_mem_to_reg(i_mem_to_reg), .i_reg_write(i_reg_write),
        .i_flush(i_flush), .o_valid(n_valid), .i_ready(i_ready),
        .o_instruction(n_instruction), .o_pc(n_pc), .o_rs2_value(n_rs2_value),
        .o_alu_result(n_alu_result), .o_branch_taken(n_branch_taken), .o_jmp_addr(n_jmp_addr),
        .o_mem_write(n_mem_write), .o_mem_read(n_mem_read), .o_mem_to_reg(n_mem_to_reg),
        .o_reg_write(n_reg_write)
    );

    function automatic logic [31:0] mk_instr(logic [6:0] f7, logic [2:0] f3, logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
    endfunction

    // Reference ALU written straight from the instruction semantics
    function automatic logic [63:0] ref_alu(logic [1:0] op, logic [31:0] instr, logic src,
                                            logic [63:0] a, logic [63:0] b);
        logic [2:0] f3;
        int sh;
        f3 = instr[14:12];
        sh = int'(b[5:0]);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        case (f3)
            3'd0: return (!src && instr[30]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            3'd3: return (a < b) ? 64'd1 : 64'd0;
            3'd4: return a ^ b;
            3'd5: return instr[30] ? 64'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_taken(logic br, logic [2:0] f3, logic [63:0] a, logic [63:0] b);
        logic c;
        case (f3)
            3'd0: c = (a == b);
            3'd1: c = (a != b);
            3'd4: c = ($signed(a) < $signed(b));
            3'd5: c = ($signed(a) >= $signed(b));
            3'd6: c = (a < b);
            3'd7: c = (a >= b);
            default: c = 1'b0;
        endcase
        return br && c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] instr, input logic [1:0] op, input logic src,
                             input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                             input logic [63:0] pc, input logic br);
        i_instruction = instr;
        i_alu_op      = op;
        i_alu_src     = src;
        i_rs1_value   = a;
        i_rs2_value   = b;
        i_immediate   = imm;
        i_pc          = pc;
        i_branch      = br;
        i_mem_write   = 1'b0;
        i_mem_read    = 1'b0;
        i_mem_to_reg  = 1'b0;
        i_reg_write   = !br;
    endtask

    // Present the current inputs until the stage accepts them (bounded)
    task automatic issue(output bit timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        i_valid = 1'b1;
        #1;
        while (!o_ready) begin
            if (n >= 200) begin
                timed_out = 1'b1;
                break;
            end
            tick();
            n++;
            #1;
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        compared += 4;
        if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
        if (o_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", o_ready); end
        if (o_alu_result !== 64'd0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", o_alu_result); end
        if (o_reg_write !== 1'b0 || o_branch_taken !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_ctrl: got rw=%b bt=%b expected 0 0", o_reg_write, o_branch_taken);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add;
        bit to;
        i_ready = 1'b1;
        set_instr(mk_instr(7'b0, 3'b000, 7'b0110011), 2'b10, 1'b0, 64'd5, 64'd7, 64'd0, 64'h40, 1'b0);
        issue(to);
        compared += 4;
        if (to) begin mismatched++; $display("[TB] FAIL add_accept: got timeout expected accept"); end
        if (o_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL add_valid: got %b expected 1", o_valid); end
        if (o_alu_result !== 64'd12) begin mismatched++; $display("[TB] FAIL add_result: got %0d expected 12", o_alu_result); end
        if (o_reg_write !== 1'b1) begin mismatched++; $display("[TB] FAIL add_regwrite: got %b expected 1", o_reg_write); end
        tick();
        compared++;
        if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL add_drain: got %b expected 0", o_valid); end
    endtask

    task automatic test_sub_sra;
        bit to;
        set_instr(mk_instr(7'b0100000, 3'b101, 7'b0110011), 2'b10, 1'b0,
                  64'h8000_0000_0000_0000, 64'd4, 64'd0, 64'h0, 1'b0);
        issue(to);
        compared++;
        if (o_alu_result !== 64'hF800_0000_0000_0000) begin
            mismatched++; $display("[TB] FAIL sra_result: got %h expected f800000000000000", o_alu_result);
        end
        set_instr(mk_instr(7'b0100000, 3'b000, 7'b0110011), 2'b10, 1'b0, 64'd3, 64'd5, 64'd0, 64'h0, 1'b0);
        issue(to);
        compared++;
        if (o_alu_result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            mismatched++; $display("[TB] FAIL sub_result: got %h expected fffffffffffffffe", o_alu_result);
        end
        set_instr(mk_instr(7'b0100000, 3'b000, 7'b0010011), 2'b10, 1'b1, 64'd3, 64'd99, 64'd5, 64'h0, 1'b0);
        issue(to);
        compared++;
        if (o_alu_result !== 64'd8) begin
            mismatched++; $display("[TB] FAIL addi_not_sub: got %h expected 8", o_alu_result);
        end
        tick();
    endtask

    task automatic test_branch;
        bit to;
        set_instr(mk_instr(7'b0, 3'b100, 7'b1100011), 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h20, 64'h100, 1'b1);
        issue(to);
        compared += 2;
        if (o_branch_taken !== 1'b1) begin mismatched++; $display("[TB] FAIL blt_taken: got %b expected 1", o_branch_taken); end
        if (o_jmp_addr !== 64'h120) begin mismatched++; $display("[TB] FAIL blt_jmp: got %h expected 120", o_jmp_addr); end
        set_instr(mk_instr(7'b0, 3'b110, 7'b1100011), 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                  64'h20, 64'h100, 1'b1);
        issue(to);
        compared++;
        if (o_branch_taken !== 1'b0) begin mismatched++; $display("[TB] FAIL bltu_taken: got %b expected 0", o_branch_taken); end
        set_instr(mk_instr(7'b0, 3'b010, 7'b1100011), 2'b01, 1'b0, 64'd1, 64'd2, 64'h20, 64'h100, 1'b1);
        issue(to);
        compared++;
        if (o_branch_taken !== 1'b0) begin mismatched++; $display("[TB] FAIL bad_f3_taken: got %b expected 0", o_branch_taken); end
        tick();
    endtask

    task automatic test_back_to_back;
        bit to;
        i_ready = 1'b0;
        set_instr(mk_instr(7'b0, 3'b000, 7'b0110011), 2'b00, 1'b0, 64'd1, 64'd1, 64'd0, 64'h200, 1'b0);
        issue(to);
        set_instr(mk_instr(7'b0, 3'b000, 7'b0110011), 2'b00, 1'b0, 64'd10, 64'd20, 64'd0, 64'h204, 1'b0);
        i_valid = 1'b1;
        #1;
        compared++;
        if (o_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_ready_low: got %b expected 0", o_ready); end
        tick();
        compared += 2;
        if (o_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold_valid: got %b expected 1", o_valid); end
        if (o_alu_result !== 64'd2 || o_pc !== 64'h200) begin
            mismatched++; $display("[TB] FAIL bp_hold_result: got %0d pc %h expected 2 pc 200", o_alu_result, o_pc);
        end
        i_ready = 1'b1;
        #1;
        compared++;
        if (o_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_ready_high: got %b expected 1", o_ready); end
        tick();
        i_valid = 1'b0;
        compared++;
        if (o_valid !== 1'b1 || o_alu_result !== 64'd30 || o_pc !== 64'h204) begin
            mismatched++; $display("[TB] FAIL bp_second: got v=%b %0d pc %h expected v=1 30 pc 204", o_valid, o_alu_result, o_pc);
        end
        tick();
        compared++;
        if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_drain: got %b expected 0", o_valid); end
    endtask

    // One multiply on the MUL_EN=1 stage; the MUL_EN=0 stage sees it as an ADD
    task automatic run_mul(input logic [63:0] a, input logic [63:0] b, input string name);
        bit to;
        int lat;
        bit ready_seen;
        logic [63:0] expect_mul;
        expect_mul = a * b;
        i_ready = 1'b1;
        set_instr(mk_instr(7'b0000001, 3'b000, 7'b0110011), 2'b10, 1'b0, a, b, 64'd0, 64'h300, 1'b0);
        issue(to);
        compared += 2;
        if (n_valid !== 1'b1 || n_alu_result !== a + b) begin
            mismatched++; $display("[TB] FAIL %s_nomul_add: got v=%b %h expected v=1 %h", name, n_valid, n_alu_result, a + b);
        end
        if (to) begin mismatched++; $display("[TB] FAIL %s_accept: got timeout expected accept", name); end
        lat = 0;
        ready_seen = 1'b0;
        while (!o_valid && lat < 200) begin
            if (o_ready) ready_seen = 1'b1;
            tick();
            lat++;
        end
        compared += 3;
        if (lat != XLEN + 1) begin mismatched++; $display("[TB] FAIL %s_latency: got %0d expected %0d", name, lat, XLEN + 1); end
        if (ready_seen) begin mismatched++; $display("[TB] FAIL %s_busy_ready: got ready=1 while busy expected 0", name); end
        if (o_alu_result !== expect_mul) begin
            mismatched++; $display("[TB] FAIL %s_result: got %h expected %h", name, o_alu_result, expect_mul);
        end
        tick();
    endtask

    task automatic test_mul;
        run_mul(64'd6, 64'd7, "mul_6x7");
        run_mul({$urandom, $urandom}, {$urandom, $urandom}, "mul_rand");
    endtask

    task automatic test_flush;
        bit to;
        int stray;
        i_ready = 1'b1;
        set_instr(mk_instr(7'b0000001, 3'b000, 7'b0110011), 2'b10, 1'b0, 64'd9, 64'd9, 64'd0, 64'h0, 1'b0);
        issue(to);
        repeat (9) tick();
        set_instr(mk_instr(7'b0, 3'b000, 7'b0110011), 2'b00, 1'b0, 64'd1, 64'd2, 64'd0, 64'h0, 1'b0);
        i_valid = 1'b1;
        i_flush = 1'b1;
        tick();
        i_valid = 1'b0;
        i_flush = 1'b0;
        #1;
        compared += 3;
        if (o_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_valid: got %b expected 0", o_valid); end
        if (o_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_ready: got %b expected 1", o_ready); end
        if (n_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_wins: got %b expected 0", n_valid); end
        stray = 0;
        repeat (XLEN + 8) begin
            tick();
            if (o_valid) stray++;
        end
        compared++;
        if (stray != 0) begin mismatched++; $display("[TB] FAIL flush_abort: got %0d valid cycles expected 0", stray); end
        i_ready = 1'b0;
        set_instr(mk_instr(7'b0, 3'b000, 7'b0110011), 2'b00, 1'b0, 64'd4, 64'd4, 64'd0, 64'h0, 1'b0);
        issue(to);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        compared++;
        if (o_valid !== 1'b0 || o_reg_write !== 1'b0) begin
            mismatched++; $display("[TB] FAIL flush_slot: got v=%b rw=%b expected 0 0", o_valid, o_reg_write);
        end
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_mul;
        bit to;
        set_instr(mk_instr(7'b0000001, 3'b000, 7'b0110011), 2'b10, 1'b0, 64'd3, 64'd3, 64'd0, 64'h0, 1'b0);
        issue(to);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
            mismatched++; $display("[TB] FAIL reset_mid_mul: got rdy=%b v=%b expected 1 0", o_ready, o_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        set_instr(mk_instr(7'b0, 3'b000, 7'b0110011), 2'b00, 1'b0, 64'd2, 64'd3, 64'd0, 64'h0, 1'b0);
        issue(to);
        compared++;
        if (o_valid !== 1'b1 || o_alu_result !== 64'd5) begin
            mismatched++; $display("[TB] FAIL post_reset_add: got v=%b %0d expected 1 5", o_valid, o_alu_result);
        end
        tick();
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e, h;
        logic [31:0] instr;
        logic [1:0]  op;
        logic        src, br;
        logic [63:0] a, b, imm, pc, bsel;
        int          left;
        for (int cyc = 0; cyc < 400; cyc++) begin
            op    = 2'($urandom_range(0, 2));
            instr = $urandom;
            instr[25] = 1'b0;
            src   = (op == 2'b01) ? 1'b0 : 1'($urandom_range(0, 1));
            a     = {$urandom, $urandom};
            b     = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            imm   = {$urandom, $urandom};
            pc    = {$urandom, $urandom};
            br    = (op == 2'b01) ? 1'($urandom_range(0, 1)) : 1'b0;
            set_instr(instr, op, src, a, b, imm, pc, br);
            i_mem_write = 1'($urandom_range(0, 1));
            i_reg_write = 1'($urandom_range(0, 1));
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_flush = ($urandom_range(0, 31) == 0);
            #1;
            compared += 2;
            if (o_valid !== (q.size() != 0)) begin
                mismatched++; $display("[TB] FAIL rand_valid: got %b expected %b", o_valid, q.size() != 0);
            end
            if (o_ready !== ((q.size() == 0) || i_ready)) begin
                mismatched++; $display("[TB] FAIL rand_ready: got %b expected %b", o_ready, (q.size() == 0) || i_ready);
            end
            if (i_flush) begin
                q.delete();
            end else begin
                if (o_valid && i_ready && q.size() != 0) begin
                    h = q.pop_front();
                    compared += 4;
                    if (o_alu_result !== h.res) begin mismatched++; $display("[TB] FAIL rand_result: got %h expected %h", o_alu_result, h.res); end
                    if (o_branch_taken !== h.taken) begin mismatched++; $display("[TB] FAIL rand_taken: got %b expected %b", o_branch_taken, h.taken); end
                    if (o_jmp_addr !== h.jmp || o_pc !== h.pc) begin
                        mismatched++; $display("[TB] FAIL rand_addr: got jmp %h pc %h expected %h %h", o_jmp_addr, o_pc, h.jmp, h.pc);
                    end
                    if (o_rs2_value !== h.rs2 || o_instruction !== h.instr ||
                        o_mem_write !== h.mem_write || o_reg_write !== h.reg_write) begin
                        mismatched++; $display("[TB] FAIL rand_pass: got %h %h %b%b expected %h %h %b%b", o_rs2_value, o_instruction,
                                               o_mem_write, o_reg_write, h.rs2, h.instr, h.mem_write, h.reg_write);
                    end
                end
                if (i_valid && o_ready) begin
                    bsel        = src ? imm : b;
                    e.res       = ref_alu(op, instr, src, a, bsel);
                    e.taken     = ref_taken(br, instr[14:12], a, bsel);
                    e.jmp       = pc + imm;
                    e.pc        = pc;
                    e.rs2       = b;
                    e.instr     = instr;
                    e.mem_write = i_mem_write;
                    e.reg_write = i_reg_write;
                    q.push_back(e);
                end
            end
            tick();
        end
        i_valid = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        left = q.size();
        tick();
        compared++;
        if (left > 1 || (left == 1 && o_valid !== 1'b0)) begin
            mismatched++; $display("[TB] FAIL rand_drain: got %0d pending v=%b expected empty", left, o_valid);
        end
    endtask

    initial begin
        $display("[TB] execute_stage_pipe bench start");
        test_reset();
        test_add();
        test_sub_sra();
        test_branch();
        test_back_to_back();
        test_mul();
        test_flush();
        test_reset_mid_mul();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
